// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the MEM pipeline stage.
//   - register/bus widths used on the ex_mem -> mem -> mem_wb path
//   - ALU op codes, including the load/store group
//   - MEM stage FSM state encoding
//   - helpers that classify an op and give its byte count
package mem_stage_pkg;

    localparam int REG_ADDR_W     = 5;
    localparam int REG_W          = 32;
    localparam int MEM_ADDR_BUS_W = 32;
    localparam int ALUOP_W        = 8;
    localparam int MEM_STATE_W    = 2;

    localparam logic [ALUOP_W-1:0] EXE_NOP_OP = 8'h00;
    localparam logic [ALUOP_W-1:0] EXE_ADD_OP = 8'h20;
    localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'hE0;
    localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'hE1;
    localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'hE3;
    localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'hE4;
    localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'hE5;
    localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'hE8;
    localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'hE9;
    localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'hEB;

    typedef enum logic [MEM_STATE_W-1:0] {
        MEM_IDLE = 2'd0,
        MEM_XFER = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    function automatic logic is_load_op(input logic [ALUOP_W-1:0] op);
        case (op)
            EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_store_op(input logic [ALUOP_W-1:0] op);
        case (op)
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Number of bytes moved over the 8-bit bus; 0 for non-memory ops.
    function automatic logic [2:0] op_nbytes(input logic [ALUOP_W-1:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 3'd1;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 3'd2;
            EXE_LW_OP, EXE_SW_OP:             return 3'd4;
            default:                          return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: 8-bit shared RAM bus plus arbiter handshake.
//   bus_req  master -> arbiter   request the bus this cycle
//   bus_gnt  arbiter -> master   grant for this cycle
//   mem_a    master -> RAM       byte address
//   mem_dout master -> RAM       write data
//   mem_wr   master -> RAM       1 = write, 0 = read
//   mem_din  RAM -> master       read data, valid one cycle after an issued read
interface mem_stage_if #(
    parameter int MEM_ADDR_W = 17
);
    logic                  bus_req;
    logic                  bus_gnt;
    logic [MEM_ADDR_W-1:0] mem_a;
    logic [7:0]            mem_dout;
    logic                  mem_wr;
    logic [7:0]            mem_din;

    modport master (
        output bus_req, mem_a, mem_dout, mem_wr,
        input  bus_gnt, mem_din
    );

    modport slave (
        input  bus_req, mem_a, mem_dout, mem_wr,
        output bus_gnt, mem_din
    );
endinterface

// File: rtl/mem_stage_load_ext.sv
// mem_load_ext: turns the little-endian assembly register into the
// architectural load value.
//   asm_data  in   32  bytes assembled from the RAM, byte k in [8k+7:8k]
//   aluop     in   8   load op code
//   load_data out  32  sign/zero-extended result (0 for non-load ops)
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [REG_W-1:0]   asm_data,
    input  logic [ALUOP_W-1:0] aluop,
    output logic [REG_W-1:0]   load_data
);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign byte_s = signed'(asm_data[7:0]);
    assign half_s = signed'(asm_data[15:0]);

    always_comb begin
        load_data = '0;
        case (aluop)
            EXE_LB_OP:  load_data = REG_W'(byte_s);
            EXE_LH_OP:  load_data = REG_W'(half_s);
            EXE_LBU_OP: load_data = REG_W'(asm_data[7:0]);
            EXE_LHU_OP: load_data = REG_W'(asm_data[15:0]);
            EXE_LW_OP:  load_data = asm_data;
            default:    load_data = '0;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Performs loads/stores byte-serially over
// the shared 8-bit RAM bus (little-endian) and stalls the pipeline while an
// access is in flight. Non-memory ops pass straight through combinationally.
//   clk, rst              clock, synchronous active-high reset
//   waddr_i/we_i/wdata_i  register write info from EX
//   mem_addr_i            effective address from EX
//   mem_aluop_i           op code
//   rt_data_i             store data from EX
//   bus                   RAM bus master port (req/gnt, addr, data, strobe)
//   waddr_o/we_o/wdata_o  to mem_wb
//   stall_req             freezes ex_mem and all earlier stages
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MEM_ADDR_W = 17
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_W-1:0]     waddr_i,
    input  logic                      we_i,
    input  logic [REG_W-1:0]          wdata_i,
    input  logic [MEM_ADDR_BUS_W-1:0] mem_addr_i,
    input  logic [ALUOP_W-1:0]        mem_aluop_i,
    input  logic [REG_W-1:0]          rt_data_i,
    mem_stage_if.master               bus,
    output logic [REG_ADDR_W-1:0]     waddr_o,
    output logic                      we_o,
    output logic [REG_W-1:0]          wdata_o,
    output logic                      stall_req
);
    mem_state_e            state;
    logic [2:0]            cnt;
    logic [1:0]            cnt_prev;
    logic                  rd_pend;
    logic [REG_W-1:0]      asm_q;

    logic                  is_load;
    logic                  is_store;
    logic                  is_mem;
    logic [2:0]            nbytes;
    logic                  req;
    logic                  issue;
    logic [2:0]            idx;
    logic [MEM_ADDR_W-1:0] byte_addr;
    logic                  store_last;
    logic                  load_last;
    logic [REG_W-1:0]      load_data;
    logic                  unused_addr_hi;

    assign is_load  = is_load_op(mem_aluop_i);
    assign is_store = is_store_op(mem_aluop_i);
    assign is_mem   = is_load | is_store;
    assign nbytes   = op_nbytes(mem_aluop_i);

    // Address bits above the RAM width are dropped; the add wraps modulo 2^MEM_ADDR_W.
    assign unused_addr_hi = ^mem_addr_i[MEM_ADDR_BUS_W-1:MEM_ADDR_W];
    assign byte_addr      = mem_addr_i[MEM_ADDR_W-1:0] + MEM_ADDR_W'(idx);

    // A store is finished as soon as its last byte is issued; a load only
    // once the last byte's read data has been captured.
    assign store_last = issue && is_store && (idx == nbytes - 3'd1);
    assign load_last  = rd_pend && ({1'b0, cnt_prev} == nbytes - 3'd1);

    mem_load_ext u_load_ext (
        .asm_data  (asm_q),
        .aluop     (mem_aluop_i),
        .load_data (load_data)
    );

    always_comb begin
        waddr_o   = '0;
        we_o      = 1'b0;
        wdata_o   = '0;
        stall_req = 1'b0;
        req       = 1'b0;
        issue     = 1'b0;
        idx       = 3'd0;
        if (!rst) begin
            case (state)
                MEM_IDLE: begin
                    if (is_mem) begin
                        stall_req = 1'b1;
                        req       = 1'b1;
                        issue     = bus.bus_gnt;
                        idx       = 3'd0;
                    end else begin
                        waddr_o = waddr_i;
                        we_o    = we_i;
                        wdata_o = wdata_i;
                    end
                end
                MEM_XFER: begin
                    stall_req = 1'b1;
                    req       = (cnt < nbytes);
                    issue     = (cnt < nbytes) && bus.bus_gnt;
                    idx       = cnt;
                end
                MEM_DONE: begin
                    waddr_o = waddr_i;
                    we_o    = we_i;
                    wdata_o = is_load ? load_data : '0;
                end
                default: begin
                    stall_req = 1'b0;
                end
            endcase
        end
    end

    assign bus.bus_req  = req;
    assign bus.mem_wr   = issue & is_store;
    assign bus.mem_a    = issue ? byte_addr : '0;
    assign bus.mem_dout = (issue & is_store) ? rt_data_i[{idx[1:0], 3'b000} +: 8] : 8'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MEM_IDLE;
            cnt      <= 3'd0;
            cnt_prev <= 2'd0;
            rd_pend  <= 1'b0;
            asm_q    <= '0;
        end else begin
            // Read data returns one cycle after issue; remember which slot it fills.
            rd_pend <= issue && is_load;
            if (issue) begin
                cnt_prev <= idx[1:0];
            end
            if (rd_pend) begin
                asm_q[{cnt_prev, 3'b000} +: 8] <= bus.mem_din;
            end

            case (state)
                MEM_IDLE: begin
                    if (is_mem && bus.bus_gnt) begin
                        cnt   <= 3'd1;
                        state <= store_last ? MEM_DONE : MEM_XFER;
                    end
                end
                MEM_XFER: begin
                    if (issue) begin
                        cnt <= cnt + 3'd1;
                    end
                    if (store_last || load_last) begin
                        state <= MEM_DONE;
                    end
                end
                MEM_DONE: begin
                    // Unconditional return so the held op is not restarted.
                    cnt   <= 3'd0;
                    state <= MEM_IDLE;
                end
                default: begin
                    cnt   <= 3'd0;
                    state <= MEM_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int AW = 17;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  waddr_i;
    logic        we_i;
    logic [31:0] wdata_i;
    logic [31:0] mem_addr_i;
    logic [7:0]  mem_aluop_i;
    logic [31:0] rt_data_i;
    logic [4:0]  waddr_o;
    logic        we_o;
    logic [31:0] wdata_o;
    logic        stall_req;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_if #(.MEM_ADDR_W(AW)) bus_if ();

    mem_stage #(.MEM_ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .waddr_i     (waddr_i),
        .we_i        (we_i),
        .wdata_i     (wdata_i),
        .mem_addr_i  (mem_addr_i),
        .mem_aluop_i (mem_aluop_i),
        .rt_data_i   (rt_data_i),
        .bus         (bus_if),
        .waddr_o     (waddr_o),
        .we_o        (we_o),
        .wdata_o     (wdata_o),
        .stall_req   (stall_req)
    );

    always #5 clk = ~clk;

    // RAM model: synchronous read (data one cycle later), write on strobe.
    logic [7:0]    ram [0:(1<<AW)-1];
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_a  = '0;
    logic [7:0]    poke_d  = '0;
    int            wr_total = 0;
    int            rd_total = 0;

    always @(posedge clk) begin
        bus_if.mem_din <= ram[bus_if.mem_a];
        if (poke_en) begin
            ram[poke_a] <= poke_d;
        end else if (bus_if.mem_wr) begin
            ram[bus_if.mem_a] <= bus_if.mem_dout;
            wr_total <= wr_total + 1;
        end
        if (bus_if.bus_req && bus_if.bus_gnt && !bus_if.mem_wr) begin
            rd_total <= rd_total + 1;
        end
    end

    task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
        poke_a  = a;
        poke_d  = d;
        poke_en = 1'b1;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
    endtask

    task automatic nop();
        @(posedge clk);
        #1;
        mem_aluop_i = EXE_NOP_OP;
        we_i        = 1'b0;
        waddr_i     = '0;
        wdata_i     = '0;
    endtask

    // Starts an op on the next cycle, optionally withholding the grant for
    // cycles [gap_start, gap_start+gap_len), and returns the stall length plus
    // the outputs of the first non-stalled cycle. stalls = -1 on timeout.
    task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                           input logic [4:0] wa, input logic wen, input int gap_start, input int gap_len,
                           output int stalls, output logic [31:0] res, output logic res_we,
                           output logic [4:0] res_wa);
        bit done;
        stalls = 0;
        done   = 1'b0;
        res    = '0;
        res_we = 1'b0;
        res_wa = '0;
        @(posedge clk);
        #1;
        mem_aluop_i = op;
        mem_addr_i  = addr;
        rt_data_i   = rt;
        waddr_i     = wa;
        we_i        = wen;
        wdata_i     = 32'hCAFE0000;
        for (int c = 0; c < 40 && !done; c++) begin
            bus_if.bus_gnt = !(c >= gap_start && c < gap_start + gap_len);
            @(negedge clk);
            if (!stall_req) begin
                done   = 1'b1;
                res    = wdata_o;
                res_we = we_o;
                res_wa = waddr_o;
            end else begin
                stalls++;
                @(posedge clk);
                #1;
            end
        end
        bus_if.bus_gnt = 1'b1;
        if (!done) stalls = -1;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        mem_aluop_i    = EXE_LW_OP;
        mem_addr_i     = 32'h100;
        waddr_i        = 5'd3;
        we_i           = 1'b1;
        wdata_i        = 32'h1111;
        rt_data_i      = 32'h2222;
        bus_if.bus_gnt = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall_req: got %b expected 0", stall_req); end
        n_checks++;
        if (bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b expected 0", bus_if.bus_req); end
        n_checks++;
        if (bus_if.mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %b expected 0", bus_if.mem_wr); end
        n_checks++;
        if (bus_if.mem_a !== '0) begin n_fail++; $display("FAIL reset_mem_a: got %h expected 0", bus_if.mem_a); end
        n_checks++;
        if (we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we_o: got %b expected 0", we_o); end
        n_checks++;
        if (wdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_wdata_o: got %h expected 0", wdata_o); end
        n_checks++;
        if (waddr_o !== 5'd0) begin n_fail++; $display("FAIL reset_waddr_o: got %h expected 0", waddr_o); end
        @(posedge clk);
        #1;
        rst         = 1'b0;
        mem_aluop_i = EXE_NOP_OP;
        we_i        = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall_req !== 1'b0) begin n_fail++; $display("FAIL post_reset_stall: got %b expected 0", stall_req); end
        n_checks++;
        if (rd_total !== 0) begin n_fail++; $display("FAIL reset_no_reads: got %0d expected 0", rd_total); end
    endtask

    task automatic test_lw();
        int st; logic [31:0] r; logic w; logic [4:0] a; int rd0;
        nop();
        poke(17'h100, 8'h78);
        poke(17'h101, 8'h56);
        poke(17'h102, 8'h34);
        poke(17'h103, 8'h12);
        rd0 = rd_total;
        run_mem(EXE_LW_OP, 32'h100, 32'h0, 5'd3, 1'b1, 99, 0, st, r, w, a);
        n_checks++;
        if (st !== 5) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d expected 5", st); end
        n_checks++;
        if (r !== 32'h12345678) begin n_fail++; $display("FAIL lw_wdata: got %h expected 12345678", r); end
        n_checks++;
        if (w !== 1'b1 || a !== 5'd3) begin n_fail++; $display("FAIL lw_we_waddr: got %b/%0d expected 1/3", w, a); end
        n_checks++;
        if (rd_total - rd0 !== 4) begin n_fail++; $display("FAIL lw_read_count: got %0d expected 4", rd_total - rd0); end
        nop();
    endtask

    task automatic test_load_ext();
        int st; logic [31:0] r; logic w; logic [4:0] a;
        poke(17'h3, 8'h80);
        poke(17'h10, 8'h34);
        poke(17'h11, 8'h92);
        run_mem(EXE_LB_OP, 32'h3, 32'h0, 5'd4, 1'b1, 99, 0, st, r, w, a);
        n_checks++;
        if (st !== 2) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d expected 2", st); end
        n_checks++;
        if (r !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_sign_ext: got %h expected ffffff80", r); end
        nop();
        run_mem(EXE_LBU_OP, 32'h3, 32'h0, 5'd4, 1'b1, 99, 0, st, r, w, a);
        n_checks++;
        if (r !== 32'h00000080) begin n_fail++; $display("FAIL lbu_zero_ext: got %h expected 00000080", r); end
        nop();
        run_mem(EXE_LH_OP, 32'h10, 32'h0, 5'd5, 1'b1, 99, 0, st, r, w, a);
        n_checks++;
        if (st !== 3) begin n_fail++; $display("FAIL lh_stall_cycles: got %0d expected 3", st); end
        n_checks++;
        if (r !== 32'hFFFF9234) begin n_fail++; $display("FAIL lh_sign_ext: got %h expected ffff9234", r); end
        nop();
        run_mem(EXE_LHU_OP, 32'h10, 32'h0, 5'd5, 1'b1, 99, 0, st, r, w, a);
        n_checks++;
        if (r !== 32'h00009234) begin n_fail++; $display("FAIL lhu_zero_ext: got %h expected 00009234", r); end
        nop();
    endtask

    task automatic test_sh_wrap();
        int st; logic [31:0] r; logic w; logic [4:0] a; int w0;
        poke(17'h1FFFF, 8'h00);
        poke(17'h00000, 8'h00);
        poke(17'h00001, 8'h77);
        w0 = wr_total;
        run_mem(EXE_SH_OP, 32'h0001FFFF, 32'hDEADBEEF, 5'd0, 1'b0, 99, 0, st, r, w, a);
        n_checks++;
        if (st !== 2) begin n_fail++; $display("FAIL sh_stall_cycles: got %0d expected 2", st); end
        n_checks++;
        if (wr_total - w0 !== 2) begin n_fail++; $display("FAIL sh_write_count: got %0d expected 2", wr_total - w0); end
        n_checks++;
        if (ram[17'h1FFFF] !== 8'hEF) begin n_fail++; $display("FAIL sh_byte0: got %h expected ef", ram[17'h1FFFF]); end
        n_checks++;
        if (ram[17'h00000] !== 8'hBE) begin n_fail++; $display("FAIL sh_byte1_wrap: got %h expected be", ram[17'h00000]); end
        n_checks++;
        if (ram[17'h00001] !== 8'h77) begin n_fail++; $display("FAIL sh_neighbour: got %h expected 77", ram[17'h00001]); end
        n_checks++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL sh_wdata: got %h expected 0", r); end
        nop();
    endtask

    task automatic test_gnt_gap();
        int st; logic [31:0] r; logic w; logic [4:0] a; int rd0;
        poke(17'h200, 8'h11);
        poke(17'h201, 8'h22);
        poke(17'h202, 8'h33);
        poke(17'h203, 8'h44);
        rd0 = rd_total;
        // byte 1 is issued in cycle 1; grant withheld in cycles 2..4
        run_mem(EXE_LW_OP, 32'h200, 32'h0, 5'd9, 1'b1, 2, 3, st, r, w, a);
        n_checks++;
        if (st !== 8) begin n_fail++; $display("FAIL gap_stall_cycles: got %0d expected 8", st); end
        n_checks++;
        if (r !== 32'h44332211) begin n_fail++; $display("FAIL gap_wdata: got %h expected 44332211", r); end
        n_checks++;
        if (rd_total - rd0 !== 4) begin n_fail++; $display("FAIL gap_read_count: got %0d expected 4", rd_total - rd0); end
        nop();
    endtask

    task automatic test_store_reset();
        int st; logic [31:0] r; logic w; logic [4:0] a; int w0;
        poke(17'h40, 8'h5A);
        poke(17'h41, 8'h5A);
        poke(17'h42, 8'h5A);
        poke(17'h43, 8'h5A);
        w0 = wr_total;
        @(posedge clk);
        #1;
        mem_aluop_i = EXE_SW_OP;
        mem_addr_i  = 32'h40;
        rt_data_i   = 32'hAABBCCDD;
        we_i        = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall_req !== 1'b1) begin n_fail++; $display("FAIL swrst_stall_c0: got %b expected 1", stall_req); end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst         = 1'b1;
        mem_aluop_i = EXE_NOP_OP;
        @(negedge clk);
        n_checks++;
        if (stall_req !== 1'b0 || bus_if.mem_wr !== 1'b0) begin
            n_fail++; $display("FAIL swrst_during_rst: got stall=%b wr=%b expected 0/0", stall_req, bus_if.mem_wr);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall_req !== 1'b0 || bus_if.bus_req !== 1'b0) begin
            n_fail++; $display("FAIL swrst_after_rst: got stall=%b req=%b expected 0/0", stall_req, bus_if.bus_req);
        end
        n_checks++;
        if (wr_total - w0 !== 2) begin n_fail++; $display("FAIL swrst_write_count: got %0d expected 2", wr_total - w0); end
        n_checks++;
        if (ram[17'h40] !== 8'hDD || ram[17'h41] !== 8'hCC) begin
            n_fail++; $display("FAIL swrst_written: got %h %h expected dd cc", ram[17'h40], ram[17'h41]);
        end
        n_checks++;
        if (ram[17'h42] !== 8'h5A || ram[17'h43] !== 8'h5A) begin
            n_fail++; $display("FAIL swrst_untouched: got %h %h expected 5a 5a", ram[17'h42], ram[17'h43]);
        end
        // FSM must be back in IDLE: a fresh LB runs with normal latency.
        run_mem(EXE_LB_OP, 32'h40, 32'h0, 5'd2, 1'b1, 99, 0, st, r, w, a);
        n_checks++;
        if (st !== 2 || r !== 32'hFFFFFFDD) begin
            n_fail++; $display("FAIL swrst_next_lb: got stalls=%0d data=%h expected 2 ffffffdd", st, r);
        end
        nop();
    endtask

    task automatic test_passthrough();
        @(posedge clk);
        #1;
        mem_aluop_i = EXE_ADD_OP;
        wdata_i     = 32'd5;
        we_i        = 1'b1;
        waddr_i     = 5'd7;
        #1;
        n_checks++;
        if (waddr_o !== 5'd7 || we_o !== 1'b1 || wdata_o !== 32'd5) begin
            n_fail++; $display("FAIL add_passthrough: got %0d/%b/%h expected 7/1/00000005", waddr_o, we_o, wdata_o);
        end
        n_checks++;
        if (stall_req !== 1'b0 || bus_if.bus_req !== 1'b0 || bus_if.mem_wr !== 1'b0) begin
            n_fail++; $display("FAIL add_no_bus: got stall=%b req=%b wr=%b expected 0/0/0",
                               stall_req, bus_if.bus_req, bus_if.mem_wr);
        end
        #1;
        wdata_i = 32'd9;
        #1;
        n_checks++;
        if (wdata_o !== 32'd9) begin n_fail++; $display("FAIL add_same_cycle: got %h expected 00000009", wdata_o); end
        nop();
    endtask

    task automatic test_back_to_back();
        int st; logic [31:0] r; logic w; logic [4:0] a;
        run_mem(EXE_SB_OP, 32'h50, 32'h123456A5, 5'd0, 1'b0, 99, 0, st, r, w, a);
        n_checks++;
        if (st !== 1) begin n_fail++; $display("FAIL b2b_sb_stall: got %0d expected 1", st); end
        run_mem(EXE_LBU_OP, 32'h50, 32'h0, 5'd6, 1'b1, 99, 0, st, r, w, a);
        n_checks++;
        if (st !== 2) begin n_fail++; $display("FAIL b2b_lbu_stall: got %0d expected 2", st); end
        n_checks++;
        if (r !== 32'h000000A5 || w !== 1'b1 || a !== 5'd6) begin
            n_fail++; $display("FAIL b2b_lbu_result: got %h/%b/%0d expected 000000a5/1/6", r, w, a);
        end
        nop();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_sh_wrap();
        test_gnt_gap();
        test_store_reset();
        test_passthrough();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
